// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared MIPS opcode/funct constants and reset PC for the decode stage
package decode_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [5:0]  OP_JAL   = 6'h03;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  FN_JR    = 6'h08;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_reg_file.sv
// rtl/decode_reg_file.sv - 32x32 register file, 2 async read ports, write-through bypass, $0 hardwired
module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] r_regs [32];
  logic        w_wr_en;

  assign w_wr_en = we && (wa != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wa] <= wd;
    end
  end

  // A write landing this cycle is visible to readers in the same cycle.
  assign rd1 = (ra1 == 5'd0)              ? '0 :
               (w_wr_en && (wa == ra1))   ? wd : r_regs[ra1];
  assign rd2 = (ra2 == 5'd0)              ? '0 :
               (w_wr_en && (wa == ra2))   ? wd : r_regs[ra2];

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - MIPS decode stage: IF/ID register, control decode, branch compare, target adders
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_plus_4_f,
  input  logic        stall_d,
  input  logic        forward_a_d,
  input  logic        forward_b_d,
  input  logic [31:0] alu_out_m,
  input  logic        reg_write_w,
  input  logic [4:0]  write_reg_w,
  input  logic [31:0] result_w,
  output logic        branch,
  output logic        jump,
  output logic        jump_reg,
  output logic [31:0] branch_addr,
  output logic [31:0] jump_addr,
  output logic [31:0] jump_reg_addr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus_4_d,
  output logic [31:0] rd1_d,
  output logic [31:0] rd2_d,
  output logic [4:0]  rs_d,
  output logic [4:0]  rt_d,
  output logic [4:0]  rd_d,
  output logic [31:0] sign_imm_d
);

  logic [31:0] r_instr_d;
  logic [31:0] r_pc_plus_4_d;

  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [31:0] w_rf1;
  logic [31:0] w_rf2;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_beq;
  logic        w_bne;
  logic        w_flush;

  // Decode sees a nop while reset is held so no control output can fire.
  assign w_instr = rst_n ? r_instr_d : NOP;
  assign w_op    = w_instr[31:26];
  assign w_fn    = w_instr[5:0];

  assign rs_d       = w_instr[25:21];
  assign rt_d       = w_instr[20:16];
  assign rd_d       = w_instr[15:11];
  assign sign_imm_d = sign_ext16(w_instr[15:0]);

  reg_file u_reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs_d),
    .ra2   (rt_d),
    .we    (reg_write_w),
    .wa    (write_reg_w),
    .wd    (result_w),
    .rd1   (w_rf1),
    .rd2   (w_rf2)
  );

  assign w_a   = forward_a_d ? alu_out_m : w_rf1;
  assign w_b   = forward_b_d ? alu_out_m : w_rf2;
  assign rd1_d = w_a;
  assign rd2_d = w_b;

  assign w_beq = (w_op == OP_BEQ);
  assign w_bne = (w_op == OP_BNE);

  assign branch   = !stall_d && ((w_beq && (w_a == w_b)) || (w_bne && (w_a != w_b)));
  assign jump     = !stall_d && ((w_op == OP_J) || (w_op == OP_JAL));
  assign jump_reg = !stall_d && (w_op == OP_RTYPE) && (w_fn == FN_JR);
  assign w_flush  = branch || jump || jump_reg;

  assign branch_addr   = r_pc_plus_4_d + {sign_imm_d[29:0], 2'b00};
  assign jump_addr     = {r_pc_plus_4_d[31:28], w_instr[25:0], 2'b00};
  assign jump_reg_addr = w_a;

  // Priority: reset > stall > flush > load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_d     <= NOP;
      r_pc_plus_4_d <= RESET_PC;
    end else if (!stall_d) begin
      r_instr_d     <= w_flush ? NOP : instr_f;
      r_pc_plus_4_d <= pc_plus_4_f;
    end
  end

  assign instr_d     = r_instr_d;
  assign pc_plus_4_d = r_pc_plus_4_d;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - randomized self-checking bench for decode against a behavioural model
module tb_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_f;
  logic [31:0] pc_plus_4_f;
  logic        stall_d;
  logic        forward_a_d;
  logic        forward_b_d;
  logic [31:0] alu_out_m;
  logic        reg_write_w;
  logic [4:0]  write_reg_w;
  logic [31:0] result_w;
  logic        branch, jump, jump_reg;
  logic [31:0] branch_addr, jump_addr, jump_reg_addr;
  logic [31:0] instr_d, pc_plus_4_d, rd1_d, rd2_d, sign_imm_d;
  logic [4:0]  rs_d, rt_d, rd_d;

  decode dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_f       (instr_f),
    .pc_plus_4_f   (pc_plus_4_f),
    .stall_d       (stall_d),
    .forward_a_d   (forward_a_d),
    .forward_b_d   (forward_b_d),
    .alu_out_m     (alu_out_m),
    .reg_write_w   (reg_write_w),
    .write_reg_w   (write_reg_w),
    .result_w      (result_w),
    .branch        (branch),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .branch_addr   (branch_addr),
    .jump_addr     (jump_addr),
    .jump_reg_addr (jump_reg_addr),
    .instr_d       (instr_d),
    .pc_plus_4_d   (pc_plus_4_d),
    .rd1_d         (rd1_d),
    .rd2_d         (rd2_d),
    .rs_d          (rs_d),
    .rt_d          (rt_d),
    .rd_d          (rd_d),
    .sign_imm_d    (sign_imm_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_flush;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (reg_write_w && write_reg_w == idx) return result_w;
    return m_rf[idx];
  endfunction

  task automatic eval_cycle();
    logic [31:0] ie, a, b, simm;
    logic [5:0]  op, fn;
    logic        e_br, e_j, e_jr;
    @(negedge clk);
    ie   = rst_n ? m_instr : 32'd0;
    op   = ie[31:26];
    fn   = ie[5:0];
    a    = forward_a_d ? alu_out_m : m_read(ie[25:21]);
    b    = forward_b_d ? alu_out_m : m_read(ie[20:16]);
    simm = {{16{ie[15]}}, ie[15:0]};
    e_br = !stall_d && ((op == 6'd4 && a == b) || (op == 6'd5 && a != b));
    e_j  = !stall_d && (op == 6'd2 || op == 6'd3);
    e_jr = !stall_d && op == 6'd0 && fn == 6'd8;
    m_flush = e_br || e_j || e_jr;
    check("instr_d", instr_d, m_instr);
    check("pc_plus_4_d", pc_plus_4_d, m_pc4);
    check("rs_d", {27'd0, rs_d}, {27'd0, ie[25:21]});
    check("rt_d", {27'd0, rt_d}, {27'd0, ie[20:16]});
    check("rd_d", {27'd0, rd_d}, {27'd0, ie[15:11]});
    check("sign_imm_d", sign_imm_d, simm);
    check("rd1_d", rd1_d, a);
    check("rd2_d", rd2_d, b);
    check("branch", {31'd0, branch}, {31'd0, e_br});
    check("jump", {31'd0, jump}, {31'd0, e_j});
    check("jump_reg", {31'd0, jump_reg}, {31'd0, e_jr});
    check("branch_addr", branch_addr, m_pc4 + simm * 4);
    check("jump_addr", jump_addr, {m_pc4[31:28], ie[25:0], 2'b00});
    check("jump_reg_addr", jump_reg_addr, a);
  endtask

  task automatic next_cycle();
    if (!rst_n) begin
      m_instr = 32'd0;
      m_pc4   = 32'h0040_0000;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      if (reg_write_w && write_reg_w != 0) m_rf[write_reg_w] = result_w;
      if (!stall_d) begin
        m_instr = m_flush ? 32'd0 : instr_f;
        m_pc4   = pc_plus_4_f;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_d = 0; forward_a_d = 0; forward_b_d = 0; alu_out_m = 0;
    reg_write_w = 0; write_reg_w = 0; result_w = 0;
    instr_f = 0; pc_plus_4_f = 32'h0040_0004;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    reg_write_w = 1; write_reg_w = r; result_w = v;
    eval_cycle(); next_cycle();
    reg_write_w = 0;
  endtask

  localparam logic [31:0] BEQ_8_9 = 32'h1109_0003;
  localparam logic [31:0] J_INSTR = 32'h0810_0040;
  localparam logic [31:0] JR_31   = 32'h03E0_0008;
  localparam logic [31:0] BNE_0_0 = 32'h1400_0004;

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  op;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: op = 6'h04;
      1: op = 6'h05;
      2: op = 6'h02;
      3: op = 6'h03;
      4: begin op = 6'h00; r[5:0] = ($urandom_range(0, 1) == 0) ? 6'h08 : r[5:0]; end
      5: op = 6'h23;
      default: op = r[31:26];
    endcase
    r[31:26] = op;
    r[25:21] = 5'($urandom_range(0, 7));
    r[20:16] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    rst_n = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    m_instr = 0; m_pc4 = 32'h0040_0000; m_flush = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;

    // Reset held for two cycles
    for (int k = 0; k < 2; k++) begin
      eval_cycle();
      check("rst_instr_d", instr_d, 32'd0);
      check("rst_pc4", pc_plus_4_d, 32'h0040_0000);
      check("rst_rd1", rd1_d, 32'd0);
      check("rst_ctl", {29'd0, branch, jump, jump_reg}, 32'd0);
      next_cycle();
    end
    rst_n = 1;

    // beq taken with flush
    wr(5'd8, 32'd5);
    wr(5'd9, 32'd5);
    instr_f = BEQ_8_9; pc_plus_4_f = 32'h0040_0010;
    eval_cycle(); next_cycle();
    instr_f = 32'h2345_6789; pc_plus_4_f = 32'h0040_0014;
    eval_cycle();
    check("beq_branch", {31'd0, branch}, 32'd1);
    check("beq_addr", branch_addr, 32'h0040_001C);
    next_cycle();
    instr_f = 0;
    eval_cycle();
    check("beq_flush", instr_d, 32'd0);
    next_cycle();

    // Same beq under stall
    instr_f = BEQ_8_9; pc_plus_4_f = 32'h0040_0010;
    eval_cycle(); next_cycle();
    instr_f = 32'h2345_6789;
    stall_d = 1;
    for (int k = 0; k < 3; k++) begin
      eval_cycle();
      check("stall_branch", {31'd0, branch}, 32'd0);
      check("stall_hold", instr_d, BEQ_8_9);
      next_cycle();
    end
    stall_d = 0;
    eval_cycle();
    check("release_branch", {31'd0, branch}, 32'd1);
    next_cycle();

    // j
    instr_f = J_INSTR; pc_plus_4_f = 32'h0040_0008;
    eval_cycle(); next_cycle();
    instr_f = 0;
    eval_cycle();
    check("j_jump", {31'd0, jump}, 32'd1);
    check("j_addr", jump_addr, 32'h0040_0100);
    next_cycle();

    // jr with writeback bypass, then forwarding priority
    instr_f = JR_31; pc_plus_4_f = 32'h0040_0020;
    eval_cycle(); next_cycle();
    instr_f = 0;
    reg_write_w = 1; write_reg_w = 5'd31; result_w = 32'h0040_0200;
    eval_cycle();
    check("jr_flag", {31'd0, jump_reg}, 32'd1);
    check("jr_bypass", jump_reg_addr, 32'h0040_0200);
    forward_a_d = 1; alu_out_m = 32'h0040_0300;
    #1;
    check("jr_forward", jump_reg_addr, 32'h0040_0300);
    next_cycle();
    idle_inputs();

    // $0 is hardwired
    wr(5'd0, 32'hFFFF_FFFF);
    instr_f = BNE_0_0;
    eval_cycle(); next_cycle();
    instr_f = 0;
    eval_cycle();
    check("r0_read", rd1_d, 32'd0);
    check("bne_r0", {31'd0, branch}, 32'd0);
    next_cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 39) != 0);
      stall_d     = ($urandom_range(0, 4) == 0);
      forward_a_d = ($urandom_range(0, 5) == 0);
      forward_b_d = ($urandom_range(0, 5) == 0);
      alu_out_m   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      reg_write_w = ($urandom_range(0, 1) == 0);
      write_reg_w = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      result_w    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      instr_f     = rand_instr();
      pc_plus_4_f = $urandom & 32'hFFFF_FFFC;
      eval_cycle();
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have ports: clk in 1 rising-edge clock; rst_n in 1 synchronous active-low reset.
REQ-002 SHALL have ports: instr_f in 32 fetched instruction; pc_plus_4_f in 32 fetch PC+4.
REQ-003 SHALL have ports: stall_d in 1 hazard-unit hold of the IF/ID register; forward_a_d, forward_b_d in 1 each, selecting alu_out_m for the rs/rt operand; alu_out_m in 32 memory-stage result.
REQ-004 SHALL have ports: reg_write_w in 1; write_reg_w in 5; result_w in 32, the writeback port.
REQ-005 SHALL have ports: branch, jump, jump_reg out 1 each; branch_addr, jump_addr, jump_reg_addr out 32 each, which drive the fetch PC muxes.
REQ-006 SHALL have ports: instr_d out 32; pc_plus_4_d out 32; rd1_d, rd2_d out 32; rs_d, rt_d, rd_d out 5; sign_imm_d out 32.

Function
REQ-007 SHALL hold the IF/ID register (instr_d, pc_plus_4_d), which loads instr_f/pc_plus_4_f on each rising clk edge, for a latency of 1 cycle.
REQ-008 SHALL, with stall_d=1, hold instr_d/pc_plus_4_d unchanged and force branch=jump=jump_reg=0.
REQ-009 SHALL flush when stall_d=0 and any of branch/jump/jump_reg is 1: the next edge loads instr_d=0 (nop) and pc_plus_4_d=pc_plus_4_f.
REQ-010 SHALL apply this priority at the IF/ID register: reset > stall > flush > load.
REQ-011 SHALL decode opcode=instr_d[31:26] and funct=instr_d[5:0] as follows: beq 0x04, bne 0x05, j 0x02, jal 0x03, jr = opcode 0x00 with funct 0x08.
REQ-012 SHALL set the operands: a = forward_a_d ? alu_out_m : rf[rs]; b = forward_b_d ? alu_out_m : rf[rt].
REQ-013 SHALL assert branch = (beq & a==b) | (bne & a!=b), combinationally.
REQ-014 SHALL assert jump for j or jal, and jump_reg for jr.
REQ-015 SHALL compute branch_addr = pc_plus_4_d + (sign_imm_d<<2), with 32-bit modulo wrap.
REQ-016 SHALL compute jump_addr = {pc_plus_4_d[31:28], instr_d[25:0], 2'b00}.
REQ-017 SHALL compute jump_reg_addr = a (the forwarded rs value).
REQ-018 SHALL compute sign_imm_d = {{16{instr_d[15]}}, instr_d[15:0]}, and set rs_d/rt_d/rd_d to instr_d[25:21]/[20:16]/[15:11].
REQ-019 SHALL drive rd1_d = a and rd2_d = b.
REQ-020 SHALL implement a 32x32 register file with 2 combinational read ports and 1 write port that writes on the rising clk edge when reg_write_w=1.
REQ-021 SHALL hardwire register 0: a write to it is ignored and a read of it returns 0.
REQ-022 SHALL bypass a same-cycle write: a read address equal to write_reg_w with reg_write_w=1 (and non-zero) returns result_w.
REQ-023 SHALL give forwarding priority over the writeback bypass when both apply.
REQ-024 SHALL resolve simultaneous flush and writeback independently: the writeback commits and the IF/ID register loads the nop.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, set instr_d=0, pc_plus_4_d=0x00400000, and all 32 registers to 0.
REQ-026 SHALL, while rst_n is held low, present nop-derived outputs: branch/jump/jump_reg=0, rs_d/rt_d/rd_d=0, sign_imm_d=0.
REQ-027 SHALL, on reset asserted mid-stall or mid-flush, take reset; the pending flush is discarded.
REQ-028 SHALL capture instr_f on the first rising edge after rst_n rises.

Structure
REQ-029 SHALL place opcode/funct constants (OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_RTYPE, FN_JR) and RESET_PC=0x00400000 in the shared MIPS package.
REQ-030 SHALL implement the register file as sub-module reg_file (ports clk, rst_n, ra1, ra2, we, wa, wd, rd1, rd2), with bypass and $0 handling inside it.
REQ-031 SHALL keep the IF/ID register, decode, branch comparator and address adders in decode.

Verification
REQ-032 SHALL cover: rst_n=0 for 2 cycles -> instr_d=0, pc_plus_4_d=0x00400000, rd1_d=0, all jump/branch outputs 0.
REQ-033 SHALL cover: write r8=5 and r9=5, then beq r8,r9,+3 at pc_plus_4=0x00400010 -> branch=1, branch_addr=0x0040001C, and instr_d=0 the next cycle.
REQ-034 SHALL cover: the same beq with stall_d=1 -> branch=0 and instr_d held for each stalled cycle; after release -> branch=1.
REQ-035 SHALL cover: j 0x0100040 at pc_plus_4=0x00400008 -> jump=1 and jump_addr=0x00400100.
REQ-036 SHALL cover: jr r31 with reg_write_w=1, write_reg_w=31, result_w=0x00400200 in the same cycle -> jump_reg_addr=0x00400200; with forward_a_d=1 and alu_out_m=0x00400300 -> 0x00400300.
REQ-037 SHALL cover: write r0=0xFFFFFFFF, then read r0 -> rd1_d=0; bne r0,r0 -> branch=0.
